// File: rtl/codec2_pkg.sv
// Shared constants, state encoding and helpers for the fpsqrt arbiter slice.
package codec2_pkg;

  localparam int unsigned N    = 32;
  localparam int unsigned Q    = 16;
  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam logic [N-1:0] POINT_FIVE = 32'h0000_8000;
  localparam logic [N-1:0] ONE        = 32'h0001_0000;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = codec2_pkg::NREQ,
  parameter int unsigned PW   = codec2_pkg::ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any_req
);

  int unsigned idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req[idx[PW-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fpsqrt_arbiter.sv
// Round-robin arbiter sharing one fpsqrt engine among NREQ requesters.
// Optional watchdog on the engine handshake: define SQRT_ARB_TIMEOUT_EN.
module fpsqrt_arbiter #(
  parameter int unsigned N    = codec2_pkg::N,
  parameter int unsigned NREQ = codec2_pkg::NREQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] x_in,
  output logic [NREQ-1:0]   done,
  output logic [N-1:0]      result,
  output logic              busy,
  output logic              sq_start,
  output logic [N-1:0]      sq_x,
  input  logic [N-1:0]      sq_result,
  input  logic              sq_done
`ifdef SQRT_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int unsigned PW = codec2_pkg::ptr_width(NREQ);

  codec2_pkg::state_e state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, ptr_next;
  logic [N-1:0]    sq_x_q, sq_x_d, result_q, result_d;
  logic            start_q, start_d, busy_q;
  logic [NREQ-1:0] done_q, done_d;
  logic [PW-1:0]   winner;
  logic            any_req;
  logic [N-1:0]    x_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign x_arr[k] = x_in[k*N +: N];
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign ptr_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam logic [7:0] WdogLimit = 8'd254;
  logic [7:0] wdog_q, wdog_d;
  logic       tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    sq_x_d   = sq_x_q;
    result_d = result_q;
    start_d  = start_q;
    done_d   = '0;
`ifdef SQRT_ARB_TIMEOUT_EN
    wdog_d   = wdog_q;
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      codec2_pkg::StIdle: begin
        if (any_req) begin
          sq_x_d  = x_arr[winner];
          start_d = 1'b1;
          owner_d = winner;
          state_d = codec2_pkg::StWait;
`ifdef SQRT_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      codec2_pkg::StWait: begin
        if (sq_done) begin
          start_d         = 1'b0;
          result_d        = sq_result;
          done_d[owner_q] = 1'b1;
          ptr_d           = ptr_next;
          state_d         = codec2_pkg::StRelease;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        // 255th waiting cycle without sq_done: complete the owner with a zero result.
        else if (wdog_q == WdogLimit) begin
          start_d         = 1'b0;
          result_d        = '0;
          done_d[owner_q] = 1'b1;
          ptr_d           = ptr_next;
          tmo_d           = 1'b1;
          state_d         = codec2_pkg::StRelease;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      codec2_pkg::StRelease: begin
        // Engine must drop sq_done before a new start can be issued.
        if (!sq_done) state_d = codec2_pkg::StIdle;
      end
      default: state_d = codec2_pkg::StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= codec2_pkg::StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      sq_x_q   <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      done_q   <= '0;
      busy_q   <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
      wdog_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      sq_x_q   <= sq_x_d;
      result_q <= result_d;
      start_q  <= start_d;
      done_q   <= done_d;
      busy_q   <= (state_d != codec2_pkg::StIdle);
`ifdef SQRT_ARB_TIMEOUT_EN
      wdog_q   <= wdog_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign sq_start = start_q;
  assign sq_x     = sq_x_q;
`ifdef SQRT_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_fpsqrt_arbiter.sv
// Scoreboard bench for fpsqrt_arbiter with a behavioural Q16.16 sqrt engine.
module tb_fpsqrt_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned R = 3;
  localparam int Bound = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [R-1:0]  req = '0;
  logic [R*W-1:0] x_in = '0;
  logic [R-1:0]  done;
  logic [W-1:0]  result;
  logic          busy;
  logic          sq_start;
  logic [W-1:0]  sq_x;
  logic [W-1:0]  sq_result;
  logic          sq_done;
`ifdef SQRT_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  fpsqrt_arbiter #(
    .N    (W),
    .NREQ (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .sq_start  (sq_start),
    .sq_x      (sq_x),
    .sq_result (sq_result),
    .sq_done   (sq_done)
`ifdef SQRT_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Engine model: result = sqrt(x * 2^16), computed from sq_x when done is raised.
  function automatic logic [31:0] isqrt_q16(input logic [31:0] x);
    logic [63:0] v;
    logic [63:0] t;
    logic [31:0] r;
    v = {16'h0, x, 16'h0};
    r = '0;
    for (int b = 23; b >= 0; b--) begin
      t = 64'(r | (32'd1 << b));
      if (t * t <= v) r = r | (32'd1 << b);
    end
    return r;
  endfunction

  int   m_lat = 3;
  int   m_cnt;
  logic m_busy;
  logic tie_low = 1'b0;

  always @(posedge clk) begin
    if (!rst || tie_low) begin
      sq_done   <= 1'b0;
      sq_result <= '0;
      m_busy    <= 1'b0;
      m_cnt     <= 0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        sq_done   <= 1'b1;
        sq_result <= isqrt_q16(sq_x);
        m_busy    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (sq_done) begin
      if (!sq_start) sq_done <= 1'b0;
    end else if (sq_start) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done != '0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=%b expected no pulse", done);
      end else begin
        mon_e = sb.pop_front();
        chk("done_onehot", 32'(done), 32'd1 << mon_e.idx);
        chk("result", result, mon_e.res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_x(input int k, input logic [31:0] v);
    x_in[k*W +: W] = v;
  endtask

  task automatic expect_done(input int k, input logic [31:0] r);
    sb.push_back('{32'(k), r});
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (done == '0 && n < Bound) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got no done pulse expected one within %0d cycles", Bound);
    end else begin
      req = req & ~done;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    @(negedge clk);
    while (!sq_start && n < Bound) begin
      @(negedge clk);
      n++;
    end
    if (!sq_start) begin
      checks++;
      failures++;
      $display("FAIL wait_start: got sq_start=0 expected 1 within %0d cycles", Bound);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (busy && n < Bound) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy=1 expected 0 within %0d cycles", Bound);
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sq_start", 32'(sq_start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_sq_x", sq_x, 32'd0);
    tick();
    rst = 1'b1;

    // Single request, one-cycle start latency.
    tick();
    put_x(0, 32'h0004_0000);
    expect_done(0, 32'h0002_0000);
    req = 3'b001;
    @(negedge clk);
    chk("start_not_early", 32'(sq_start), 32'd0);
    @(negedge clk);
    chk("start_latency", 32'(sq_start), 32'd1);
    chk("start_sq_x", sq_x, 32'h0004_0000);
    chk("start_busy", 32'(busy), 32'd1);
    wait_done();
    wait_idle();

    // Simultaneous requests after reset: served 0, 1, 2.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    put_x(0, 32'h0001_0000);
    put_x(1, 32'h0009_0000);
    put_x(2, 32'h0010_0000);
    expect_done(0, 32'h0001_0000);
    expect_done(1, 32'h0003_0000);
    expect_done(2, 32'h0004_0000);
    req = 3'b111;
    repeat (3) wait_done();
    wait_idle();

    // Fairness: requester 0 re-asserts at once, requester 1 goes first.
    put_x(0, 32'h0004_0000);
    put_x(1, 32'h0019_0000);
    expect_done(0, 32'h0002_0000);
    expect_done(1, 32'h0005_0000);
    expect_done(0, 32'h0008_0000);
    req = 3'b011;
    wait_done();
    tick();
    put_x(0, 32'h0040_0000);
    req[0] = 1'b1;
    wait_done();
    wait_done();
    wait_idle();

    // Reset during WAIT: no done, then arbitration restarts from pointer 0.
    m_lat = 20;
    put_x(0, 32'h0004_0000);
    req = 3'b001;
    wait_start();
    repeat (3) tick();
    rst = 1'b0;
    req = '0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sq_start", 32'(sq_start), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    m_lat = 3;
    tick();
    put_x(0, 32'h0001_0000);
    put_x(2, 32'h0009_0000);
    expect_done(0, 32'h0001_0000);
    expect_done(2, 32'h0003_0000);
    req = 3'b101;
    wait_done();
    wait_done();
    wait_idle();
    put_x(1, 32'h0009_0000);
    expect_done(1, 32'h0003_0000);
    req = 3'b010;
    wait_done();
    wait_idle();

    // Operand hold: x_in changes while the engine is working.
    m_lat = 6;
    put_x(0, 32'h0010_0000);
    expect_done(0, 32'h0004_0000);
    req = 3'b001;
    wait_start();
    tick();
    put_x(0, 32'h0001_0000);
    @(negedge clk);
    chk("hold_sq_x", sq_x, 32'h0010_0000);
    wait_done();
    wait_idle();
    m_lat = 3;

    // Idle with no requests stays idle.
    req = '0;
    repeat (4) tick();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sq_start", 32'(sq_start), 32'd0);

`ifdef SQRT_ARB_TIMEOUT_EN
    chk("tmo_before", 32'(timeout_err), 32'd0);
    tie_low = 1'b1;
    put_x(0, 32'h0004_0000);
    expect_done(0, 32'h0000_0000);
    req = 3'b001;
    wait_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < Bound);
    chk("tmo_cycles", 32'(n), 32'd255);
    req = '0;
    wait_idle();
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    repeat (3) tick();
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
    tie_low = 1'b0;
`endif

    repeat (2) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpsqrt_arbiter.md
FPSQRT_ARBITER -- requirements
Module: fpsqrt_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 32, meaning the operand/result width (Q16.16: 1 sign, 15 integer, 16 fraction bits).
REQ-002 The module SHALL have parameter NREQ, default 3, meaning the number of requesters sharing one fpsqrt instance.
REQ-003 The module SHALL have ports, in order:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset; synchronous, active-low
- req  in  NREQ  per-requester request level
- x_in  in  NREQ*N  packed operands; requester k uses bits [k*N +: N]
- done  out  NREQ  one-cycle completion pulse for requester k
- result  out  N  shared square-root result; valid while done[k] is high and held until the next completion
- busy  out  1  high when not IDLE
- sq_start  out  1  start to fpsqrt
- sq_x  out  N  operand to fpsqrt
- sq_result  in  N  fpsqrt result
- sq_done  in  1  fpsqrt completion

Function
REQ-004 The block SHALL use states IDLE, WAIT and RELEASE, with registered outputs only.
REQ-005 In IDLE with any req bit high, the block SHALL pick a round-robin winner k, starting its search at pointer ptr.
REQ-006 On that same edge the block SHALL load sq_x with x_in[k], set sq_start to 1, latch k as owner, and enter WAIT.
REQ-007 In WAIT the block SHALL hold sq_start at 1 and sq_x stable until sq_done is sampled high.
REQ-008 On the sq_done edge the block SHALL, in one step:
- set sq_start to 0
- load result with sq_result
- set done[owner] to 1
- set ptr to (owner+1) mod NREQ
- enter RELEASE
REQ-009 In RELEASE the block SHALL clear done, and SHALL return to IDLE only once sq_done is sampled low.
REQ-010 In RELEASE the block SHALL ignore req[owner]; a requester SHALL drop req within one cycle of its done pulse.
REQ-011 A req change while in WAIT or RELEASE SHALL NOT alter the in-flight operation or the owner.
REQ-012 Simultaneous requests SHALL be served one at a time in order ptr, ptr+1, ..., with no requester starved beyond NREQ-1 other services.
REQ-013 The latency from a req sampled in IDLE with the engine free to sq_start high SHALL be 1 cycle.
REQ-014 The latency from sq_done sampled high to the done pulse SHALL be 1 cycle.
REQ-015 A req of all zeros in IDLE SHALL leave all state unchanged.
REQ-016 At most one done bit SHALL be high in any cycle.
REQ-017 busy SHALL be 0 only in IDLE.

Reset
REQ-018 When rst is low at a clock edge, the block SHALL go to IDLE and set ptr, sq_start, done and busy to 0, and sq_x, result and owner to 0.
REQ-019 A reset during WAIT SHALL abandon the operation with no done pulse, and the block SHALL re-arbitrate from ptr=0.
REQ-020 fpsqrt SHALL be reset by the same rst, so that no stale sq_done is seen after reset.

Configuration
REQ-021 With SQRT_ARB_TIMEOUT_EN defined:
- an 8-bit watchdog SHALL count cycles in WAIT
- if sq_done is not seen after 255 cycles, the block SHALL set sq_start to 0, set result to 0, pulse done[owner], and set sticky output timeout_err (1 bit; cleared only by reset)
- the block SHALL then enter RELEASE
REQ-022 Without SQRT_ARB_TIMEOUT_EN, neither the watchdog nor the timeout_err port SHALL exist, and WAIT SHALL last indefinitely.

Structure
REQ-023 Shared package codec2_pkg SHALL hold N=32, Q=16, NREQ, the state encoding, and the Q16.16 constants POINT_FIVE and ONE.
REQ-024 The round-robin pick SHALL be the combinational sub-module rr_pick (inputs req and ptr; outputs winner index and any_req); no other sub-modules.

Verification
REQ-025 Single request: req=001 with x_in[0]=0x00040000 (4.0) -> sq_start rises next cycle; on sq_done, done=001 one cycle later with result=0x00020000 (2.0).
REQ-026 Simultaneous requests after reset: req=111 with operands 1.0, 9.0 and 16.0 -> done pulses in order 001, 010, 100 with results 0x00010000, 0x00030000 and 0x00040000.
REQ-027 Fairness: req[0] re-asserted immediately after its done while req[1] is pending -> requester 1 is served before requester 0 again.
REQ-028 Reset mid-operation: rst low for 1 cycle during WAIT -> no done pulse, busy=0 and sq_start=0 next cycle; a later req=010 is served normally.
REQ-029 Timeout with SQRT_ARB_TIMEOUT_EN, sq_done tied low: req=001 -> done=001 with result=0 after 255 WAIT cycles, and timeout_err stays 1.
REQ-030 Hold check: x_in[0] changed during WAIT -> sq_x is unchanged and result matches the original operand.
